// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions and the shifter state encoding.
package uart_pkg;

    // Register offsets as seen on addrBus[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_SHIFT   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;
    localparam int ST_INTEN   = 16;

    // CTRL bit positions
    localparam int CTRL_INTEN   = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; flush wins over push and pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

    // Storage array; no reset needed since reads are gated by the count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: bus register file, 16-deep byte FIFO and
// a baud-timed 8N1 shifter with optional even parity.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// TX_IDLE   | line high, waiting for the FIFO to hold a byte
// TX_START  | driving the start bit (0)
// TX_DATA   | driving data bits LSB first, r_bit_idx = bit being sent
// TX_PARITY | driving the even-parity bit (only when PARITY_EN)
// TX_STOP   | driving the stop bit (1); chains straight into START if more
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 868,
    parameter int FIFO_AW   = 4,
    parameter int PARITY_EN = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [31:0] addrBus,
    input  logic [3:0]  weBus,
    input  logic [31:0] dataInBus,
    output logic [31:0] dataOut,
    output logic        txInt,
    output logic        uartTx
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    tx_state_t   r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_tx;
    logic        r_int_en;
    logic        r_ovf;
    logic        r_tx_int;
    logic [31:0] r_data_out;

    logic [1:0]       w_sel;
    logic             w_wr0;
    logic             w_rd;
    logic             w_push_req;
    logic             w_ctrl_wr;
    logic             w_flush;
    logic             w_pop;
    logic             w_bit_end;
    logic             w_ovf_set;
    logic [7:0]       w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [FIFO_AW:0] w_fifo_count;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_mux;
    logic             w_unused_bits;

    assign w_sel      = addrBus[3:2];
    assign w_wr0      = en & weBus[0];
    assign w_rd       = en & (weBus == 4'b0000);
    assign w_push_req = w_wr0 & (w_sel == REG_DATA);
    assign w_ctrl_wr  = w_wr0 & (w_sel == REG_CTRL);
    assign w_flush    = w_ctrl_wr & dataInBus[CTRL_FLUSH];
    assign w_bit_end  = (r_baud_cnt == 16'd0);

    // A new byte is taken from the FIFO when idle, or at the very end of a
    // stop bit so frames run back to back. A flush blocks the pop.
    assign w_pop = ~w_fifo_empty & ~w_flush &
                   ((r_state == TX_IDLE) | ((r_state == TX_STOP) & w_bit_end));

    // A dropped byte: full FIFO with no pop freeing a slot this cycle
    assign w_ovf_set = w_push_req & w_fifo_full & ~w_pop & ~w_flush;

    assign w_unused_bits = ^{addrBus[31:4], addrBus[1:0], dataInBus[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push_req),
        .i_wdata (dataInBus[7:0]),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // STATUS word assembly
    always_comb begin
        w_status                            = '0;
        w_status[ST_FULL]                   = w_fifo_full;
        w_status[ST_EMPTY]                  = w_fifo_empty;
        w_status[ST_SHIFT]                  = (r_state != TX_IDLE);
        w_status[ST_OVF]                    = r_ovf;
        w_status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(w_fifo_count);
        w_status[ST_INTEN]                  = r_int_en;
    end

    // Read-data select; DATA and the reserved slot read as zero
    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_STATUS: w_rd_mux = w_status;
            REG_CTRL:   w_rd_mux = {31'b0, r_int_en};
            default:    w_rd_mux = '0;
        endcase
    end

    // Registered read port: updates only on a bus read, otherwise holds
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_out <= '0;
        end else if (w_rd) begin
            r_data_out <= w_rd_mux;
        end
    end

    // Control bits, sticky overflow and the registered interrupt level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_int_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_tx_int <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_int_en <= dataInBus[CTRL_INTEN];
            end
            if (w_ctrl_wr && dataInBus[CTRL_CLR_OVF]) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            r_tx_int <= r_int_en & w_fifo_empty & (r_state == TX_IDLE);
        end
    end

    // Shifter FSM with baud down-counter; the line value is registered here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= TX_IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_fifo_rdata;
                        r_par      <= ^w_fifo_rdata;
                        r_baud_cnt <= BAUD_RELOAD;
                        r_bit_idx  <= 3'd0;
                        r_tx       <= 1'b0;
                        r_state    <= TX_START;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= BAUD_RELOAD;
                        r_tx       <= r_shift[0];
                        r_state    <= TX_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_par;
                                r_state <= TX_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= TX_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                TX_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= BAUD_RELOAD;
                        r_tx       <= 1'b1;
                        r_state    <= TX_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift    <= w_fifo_rdata;
                            r_par      <= ^w_fifo_rdata;
                            r_baud_cnt <= BAUD_RELOAD;
                            r_bit_idx  <= 3'd0;
                            r_tx       <= 1'b0;
                            r_state    <= TX_START;
                        end else begin
                            r_baud_cnt <= 16'd0;
                            r_tx       <= 1'b1;
                            r_state    <= TX_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                default: begin
                    r_baud_cnt <= 16'd0;
                    r_tx       <= 1'b1;
                    r_state    <= TX_IDLE;
                end
            endcase
        end
    end

    assign dataOut = r_data_out;
    assign txInt   = r_tx_int;
    assign uartTx  = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (fast 8N1, slower 8N1, fast with
// parity) checked every cycle against a queue/frame-position model, plus
// directed literal expectations and a line decoder that counts frames.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_s [3];
    logic        en_s   [3];
    logic [31:0] addr_s [3];
    logic [3:0]  we_s   [3];
    logic [31:0] din_s  [3];
    logic [31:0] dout_s [3];
    logic        int_s  [3];
    logic        tx_s   [3];

    uart_tx_fifo #(.BAUD_DIV(4), .FIFO_AW(4), .PARITY_EN(0)) u_a (
        .clk(clk), .rstn(rstn_s[0]), .en(en_s[0]), .addrBus(addr_s[0]),
        .weBus(we_s[0]), .dataInBus(din_s[0]), .dataOut(dout_s[0]),
        .txInt(int_s[0]), .uartTx(tx_s[0]));

    uart_tx_fifo #(.BAUD_DIV(20), .FIFO_AW(4), .PARITY_EN(0)) u_b (
        .clk(clk), .rstn(rstn_s[1]), .en(en_s[1]), .addrBus(addr_s[1]),
        .weBus(we_s[1]), .dataInBus(din_s[1]), .dataOut(dout_s[1]),
        .txInt(int_s[1]), .uartTx(tx_s[1]));

    uart_tx_fifo #(.BAUD_DIV(4), .FIFO_AW(4), .PARITY_EN(1)) u_p (
        .clk(clk), .rstn(rstn_s[2]), .en(en_s[2]), .addrBus(addr_s[2]),
        .weBus(we_s[2]), .dataInBus(din_s[2]), .dataOut(dout_s[2]),
        .txInt(int_s[2]), .uartTx(tx_s[2]));

    function automatic int bd_of(int i);
        return (i == 1) ? 20 : 4;
    endfunction

    function automatic int pe_of(int i);
        return (i == 2) ? 1 : 0;
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_q     [3][16];
    int          m_head  [3];
    int          m_cnt   [3];
    logic        m_act   [3];
    int          m_pos   [3];
    logic [7:0]  m_byte  [3];
    logic        m_ovf   [3];
    logic        m_inten [3];
    logic        m_int   [3];
    logic [31:0] m_dout  [3];

    function automatic logic [31:0] m_status(int i);
        logic [31:0] s;
        s = 32'd0;
        s[0]    = (m_cnt[i] == 16);
        s[1]    = (m_cnt[i] == 0);
        s[2]    = m_act[i];
        s[3]    = m_ovf[i];
        s[8:4]  = 5'(m_cnt[i]);
        s[16]   = m_inten[i];
        return s;
    endfunction

    function automatic logic exp_tx(int i);
        int k;
        if (!m_act[i]) return 1'b1;
        k = m_pos[i] / bd_of(i);
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[i][k-1];
        if (k == 9 && pe_of(i) == 1) return ^m_byte[i];
        return 1'b1;
    endfunction

    task automatic model_reset(int i);
        m_head[i] = 0; m_cnt[i] = 0; m_act[i] = 1'b0; m_pos[i] = 0;
        m_byte[i] = 8'd0; m_ovf[i] = 1'b0; m_inten[i] = 1'b0;
        m_int[i] = 1'b0; m_dout[i] = 32'd0;
    endtask

    task automatic model_step(int i);
        int b;
        int len;
        logic [1:0] a;
        logic wr, ctrlw, fl, rd, ending, pop, nint;
        b     = bd_of(i);
        len   = (10 + pe_of(i)) * b;
        a     = addr_s[i][3:2];
        wr    = en_s[i] && we_s[i][0] && (a == 2'd0);
        ctrlw = en_s[i] && we_s[i][0] && (a == 2'd2);
        fl    = ctrlw && din_s[i][1];
        rd    = en_s[i] && (we_s[i] == 4'd0);
        ending = m_act[i] && (m_pos[i] == len - 1);
        pop   = (m_cnt[i] > 0) && !fl && (!m_act[i] || ending);
        nint  = m_inten[i] && (m_cnt[i] == 0) && !m_act[i];
        if (rd) m_dout[i] = (a == 2'd1) ? m_status(i) :
                            (a == 2'd2) ? {31'd0, m_inten[i]} : 32'd0;
        if (pop) begin
            m_byte[i] = m_q[i][m_head[i]];
            m_head[i] = (m_head[i] + 1) % 16;
            m_cnt[i]--;
            m_act[i] = 1'b1;
            m_pos[i] = 0;
        end else if (ending) begin
            m_act[i] = 1'b0;
        end else if (m_act[i]) begin
            m_pos[i]++;
        end
        if (fl) begin
            m_cnt[i] = 0;
        end else if (wr) begin
            if (m_cnt[i] < 16) begin
                m_q[i][(m_head[i] + m_cnt[i]) % 16] = din_s[i][7:0];
                m_cnt[i]++;
            end else begin
                m_ovf[i] = 1'b1;
            end
        end
        if (ctrlw) begin
            m_inten[i] = din_s[i][0];
            if (din_s[i][2]) m_ovf[i] = 1'b0;
        end
        m_int[i] = nint;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn_s[i]) model_reset(i);
            else model_step(i);
        end
    end

    // ---------------- per-cycle compare and line decoder ----------------
    logic       d_busy   [3];
    int         d_cyc    [3];
    logic [7:0] d_byte   [3];
    int         d_frames [3];
    logic [7:0] d_last   [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("uartTx[%0d]", i), 32'(tx_s[i]), 32'(exp_tx(i)));
            check($sformatf("txInt[%0d]", i), 32'(int_s[i]), 32'(m_int[i]));
            check($sformatf("dataOut[%0d]", i), dout_s[i], m_dout[i]);
            if (!rstn_s[i]) begin
                d_busy[i] = 1'b0;
            end else if (!d_busy[i]) begin
                if (tx_s[i] == 1'b0) begin
                    d_busy[i] = 1'b1;
                    d_cyc[i]  = 0;
                end
            end else begin
                d_cyc[i]++;
                if ((d_cyc[i] % bd_of(i)) == bd_of(i) / 2 &&
                    d_cyc[i] / bd_of(i) >= 1 && d_cyc[i] / bd_of(i) <= 8)
                    d_byte[i][d_cyc[i] / bd_of(i) - 1] = tx_s[i];
                if (d_cyc[i] == (10 + pe_of(i)) * bd_of(i) - 1) begin
                    d_busy[i] = 1'b0;
                    d_frames[i]++;
                    d_last[i] = d_byte[i];
                end
            end
        end
    end

    // ---------------- bus tasks (called at a negedge) ----------------
    task automatic wr(int i, int a, logic [31:0] d);
        en_s[i] = 1'b1; addr_s[i] = 32'(a << 2); we_s[i] = 4'h1; din_s[i] = d;
        @(negedge clk);
        en_s[i] = 1'b0; we_s[i] = 4'h0; din_s[i] = 32'd0;
    endtask

    task automatic rd(int i, int a, output logic [31:0] v);
        en_s[i] = 1'b1; addr_s[i] = 32'(a << 2); we_s[i] = 4'h0;
        @(negedge clk);
        en_s[i] = 1'b0;
        v = dout_s[i];
    endtask

    logic [31:0] v;
    logic        s [40];
    int          f0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn_s[i] = 1'b0; en_s[i] = 1'b0; addr_s[i] = 32'd0;
            we_s[i] = 4'd0; din_s[i] = 32'd0;
            d_busy[i] = 1'b0; d_cyc[i] = 0; d_byte[i] = 8'd0;
            d_frames[i] = 0; d_last[i] = 8'd0;
            model_reset(i);
        end
        repeat (2) @(negedge clk);
        check("reset_tx", 32'(tx_s[0]), 32'd1);
        check("reset_int", 32'(int_s[0]), 32'd0);
        check("reset_dout", dout_s[0], 32'd0);
        for (int i = 0; i < 3; i++) rstn_s[i] = 1'b1;
        @(negedge clk);
        rd(0, 1, v);
        check("reset_status", v, 32'h2);

        // single byte 0x55: start, 1,0,1,0,1,0,1,0, stop -- 4 cycles each
        begin
            logic [9:0] exp55;
            exp55 = 10'b1_01010101_0;
            wr(0, 0, 32'h55);
            check("pre_start_high", 32'(tx_s[0]), 32'd1);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                s[c] = tx_s[0];
            end
            for (int k = 0; k < 10; k++)
                check($sformatf("b55_bit%0d", k),
                      32'({s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]}),
                      32'({4{exp55[k]}}));
            @(negedge clk);
            check("b55_idle_after", 32'(tx_s[0]), 32'd1);
        end

        // back-to-back frames, no idle gap
        wr(0, 0, 32'hA5);
        wr(0, 0, 32'h3C);
        rd(0, 1, v);
        check("b2b_count", 32'(v[8:4]), 32'd1);
        repeat (38) @(negedge clk);
        check("b2b_a5_stop", 32'(tx_s[0]), 32'd1);
        @(negedge clk);
        check("b2b_3c_start", 32'(tx_s[0]), 32'd0);
        repeat (50) @(negedge clk);
        check("b2b_last_byte", 32'(d_last[0]), 32'h3C);

        // overflow on the slow instance: prime a frame, then 17 writes
        wr(1, 0, 32'h11);
        for (int k = 0; k < 17; k++) wr(1, 0, 32'(8'h20 + k));
        rd(1, 1, v);
        check("ovf_status", v, 32'h10D);
        wr(1, 2, 32'h4);
        rd(1, 1, v);
        check("ovf_cleared", v, 32'h105);
        repeat (3450) @(negedge clk);
        check("ovf_frames", 32'(d_frames[1]), 32'd17);
        check("ovf_last_byte", 32'(d_last[1]), 32'h2F);
        rd(1, 1, v);
        check("ovf_drained", v, 32'h2);

        // interrupt
        wr(0, 2, 32'h1);
        wr(0, 0, 32'h81);
        repeat (4) @(negedge clk);
        check("int_low_shifting", 32'(int_s[0]), 32'd0);
        repeat (37) @(negedge clk);
        check("int_lag", 32'(int_s[0]), 32'd0);
        @(negedge clk);
        check("int_rise", 32'(int_s[0]), 32'd1);
        wr(0, 0, 32'h00);
        check("int_hold", 32'(int_s[0]), 32'd1);
        @(negedge clk);
        check("int_drop", 32'(int_s[0]), 32'd0);
        repeat (50) @(negedge clk);
        wr(0, 2, 32'h0);

        // flush mid-frame
        f0 = d_frames[0];
        for (int k = 1; k <= 5; k++) wr(0, 0, 32'(k));
        wr(0, 2, 32'h2);
        rd(0, 1, v);
        check("flush_status", v, 32'h6);
        repeat (60) @(negedge clk);
        check("flush_frames", 32'(d_frames[0] - f0), 32'd1);
        check("flush_byte", 32'(d_last[0]), 32'h01);
        rd(0, 1, v);
        check("flush_idle", v, 32'h2);

        // parity 0x07: bit7=0, parity=1, frame 44 cycles
        wr(2, 0, 32'h07);
        repeat (36) @(negedge clk);
        check("par_bit7", 32'(tx_s[2]), 32'd0);
        @(negedge clk);
        check("par_bit", 32'(tx_s[2]), 32'd1);
        repeat (7) @(negedge clk);
        rd(2, 1, v);
        check("par_len_shifting", 32'(v[2]), 32'd1);
        rd(2, 1, v);
        check("par_len_done", 32'(v[2]), 32'd0);

        // async reset mid-DATA
        wr(2, 0, 32'h00);
        wr(2, 0, 32'h99);
        repeat (6) @(negedge clk);
        check("pre_reset_low", 32'(tx_s[2]), 32'd0);
        #2 rstn_s[2] = 1'b0;
        #1 check("reset_async_high", 32'(tx_s[2]), 32'd1);
        @(negedge clk);
        #3 rstn_s[2] = 1'b1;
        rd(2, 1, v);
        check("reset_empty", v, 32'h2);
        repeat (60) @(negedge clk);
        check("reset_line_idle", 32'(tx_s[2]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
